// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button conditioning logic.
package key_pkg;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        RELEASED,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } key_state_t;

    // Counter width. It must hold values up to LONG_CYCLES so that neither
    // the stability counter nor the hold counter can wrap.
    function automatic int cnt_width(input int long_cycles);
        return $clog2(long_cycles + 1);
    endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// One-bit two-flop synchroniser for asynchronous pad inputs.
// Both flops reset to RST_VAL, which should be the idle level of the pad.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the pad through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronises the pad, debounces it with a
// stability counter, and emits registered press / release / long-press
// pulses alongside a clean "pressed" level.
module key_debounce
    import key_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 270000,
    parameter int   LONG_CYCLES     = 27000000,
    parameter logic INV_BTN         = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic key_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    localparam int            CW        = cnt_width(LONG_CYCLES);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

    logic          sync_key;
    logic          pressed;
    key_state_t    state_q;
    logic [CW-1:0] stab_q;
    logic [CW-1:0] hold_q;
    logic          long_flag_q;
    logic          key_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic [CW-1:0] hold_d;
    logic          long_hit_d;

    // Synchroniser idles at the released pad level so reset looks "not pressed".
    sync_2ff #(
        .RST_VAL (INV_BTN)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (key_i),
        .q_o   (sync_key)
    );

    assign pressed = sync_key ^ INV_BTN;

    // Saturating hold-count step and the one-shot long-press condition.
    always_comb begin
        hold_d     = (hold_q == LONG_LAST) ? hold_q : hold_q + CW'(1);
        long_hit_d = (hold_q == LONG_LAST) && !long_flag_q;
    end

    // Debounce FSM with counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RELEASED;
            stab_q      <= '0;
            hold_q      <= '0;
            long_flag_q <= 1'b0;
            key_q       <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (pressed) begin
                        state_q <= DB_PRESS;
                        stab_q  <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!pressed) begin
                        state_q <= RELEASED;
                    end else if (stab_q == DB_LAST) begin
                        state_q     <= PRESSED;
                        key_q       <= 1'b1;
                        press_q     <= 1'b1;
                        hold_q      <= '0;
                        long_flag_q <= 1'b0;
                    end else begin
                        stab_q <= stab_q + CW'(1);
                    end
                end
                PRESSED: begin
                    hold_q <= hold_d;
                    if (long_hit_d) begin
                        long_q      <= 1'b1;
                        long_flag_q <= 1'b1;
                    end
                    if (!pressed) begin
                        state_q <= DB_RELEASE;
                        stab_q  <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (!pressed && stab_q == DB_LAST) begin
                        // Release acceptance wins over a coincident long pulse.
                        state_q   <= RELEASED;
                        key_q     <= 1'b0;
                        release_q <= 1'b1;
                        hold_q    <= '0;
                    end else begin
                        // Hold time keeps accumulating while the release is unconfirmed.
                        hold_q <= hold_d;
                        if (long_hit_d) begin
                            long_q      <= 1'b1;
                            long_flag_q <= 1'b1;
                        end
                        if (pressed) begin
                            state_q <= PRESSED;
                        end else begin
                            stab_q <= stab_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= RELEASED;
                end
            endcase
        end
    end

    assign key_o     = key_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// active-low pad. Cycle c is the cycle following the clock edge that samples
// key_vec[c]; outputs are sampled 1 time unit after each edge.
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_i = 1'b1;
    logic key_o, press_o, release_o, long_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic key_vec [64];
    logic ko_log  [64];
    int   n_press, first_press, n_rel, first_rel, n_long, first_long, n_ko, n_overlap;

    key_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .INV_BTN         (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_i     (key_i),
        .key_o     (key_o),
        .press_o   (press_o),
        .release_o (release_o),
        .long_o    (long_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_key(input int lo, input int hi, input logic v);
        for (int i = lo; i <= hi; i++) key_vec[i] = v;
    endtask

    // Reset with the pad at key_val, checking that outputs are cleared.
    task automatic do_reset(input logic key_val, input string tag);
        rst_n = 1'b0;
        key_i = key_val;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_rst_outs"}, {28'd0, key_o, press_o, release_o, long_o}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Apply key_vec[0..n-1], one value per clock edge, and summarise outputs.
    task automatic run_vec(input int n);
        n_press = 0; first_press = -1;
        n_rel = 0;   first_rel = -1;
        n_long = 0;  first_long = -1;
        n_ko = 0;    n_overlap = 0;
        for (int c = 0; c < n; c++) begin
            key_i = key_vec[c];
            @(posedge clk);
            #1;
            ko_log[c] = key_o;
            if (key_o) n_ko++;
            if (press_o) begin n_press++; if (first_press < 0) first_press = c; end
            if (release_o) begin n_rel++; if (first_rel < 0) first_rel = c; end
            if (long_o) begin n_long++; if (first_long < 0) first_long = c; end
            if (int'(press_o) + int'(release_o) + int'(long_o) > 1) n_overlap++;
        end
    endtask

    initial begin
        // Reset with button held: press after normal debounce latency.
        do_reset(1'b0, "reset");
        set_key(0, 63, 1'b0);
        run_vec(10);
        chk("reset_press_cnt", n_press, 1);
        chk("reset_press_cyc", first_press, 6);
        chk("reset_ko_c5", ko_log[5], 0);
        chk("reset_ko_c6", ko_log[6], 1);
        chk("reset_rel_cnt", n_rel, 0);

        // Clean press then release at edge 10.
        do_reset(1'b1, "clean");
        set_key(0, 9, 1'b0);
        set_key(10, 63, 1'b1);
        run_vec(24);
        chk("clean_press_cnt", n_press, 1);
        chk("clean_press_cyc", first_press, 6);
        chk("clean_rel_cnt", n_rel, 1);
        chk("clean_rel_cyc", first_rel, 16);
        chk("clean_ko_c15", ko_log[15], 1);
        chk("clean_ko_c16", ko_log[16], 0);
        chk("clean_ko_cnt", n_ko, 10);
        chk("clean_long_cnt", n_long, 0);

        // Bounce: toggle every 2 cycles for 12 cycles, then hold pressed.
        do_reset(1'b1, "bounce");
        for (int c = 0; c < 12; c++) key_vec[c] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
        set_key(12, 63, 1'b0);
        run_vec(30);
        chk("bounce_press_cnt", n_press, 1);
        chk("bounce_press_cyc", first_press, 18);
        chk("bounce_rel_cnt", n_rel, 0);
        chk("bounce_ko_c17", ko_log[17], 0);

        // Long press: held 40 cycles.
        do_reset(1'b1, "long");
        set_key(0, 39, 1'b0);
        set_key(40, 63, 1'b1);
        run_vec(52);
        chk("long_press_cyc", first_press, 6);
        chk("long_long_cnt", n_long, 1);
        chk("long_long_cyc", first_long, 26);
        chk("long_rel_cnt", n_rel, 1);
        chk("long_rel_cyc", first_rel, 46);
        chk("long_overlap", n_overlap, 0);

        // Release bounce at hold count 10, then pressed again.
        do_reset(1'b1, "rbounce");
        set_key(0, 63, 1'b0);
        set_key(16, 17, 1'b1);
        run_vec(30);
        chk("rbounce_press_cnt", n_press, 1);
        chk("rbounce_rel_cnt", n_rel, 0);
        chk("rbounce_ko_cnt", n_ko, 24);
        chk("rbounce_long_cnt", n_long, 1);
        chk("rbounce_long_cyc", first_long, 26);

        // Asynchronous reset while holding with hold count at 10.
        do_reset(1'b1, "areset");
        set_key(0, 63, 1'b0);
        run_vec(17);
        chk("areset_press_cyc", first_press, 6);
        chk("areset_ko_before", key_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_outs_now", {28'd0, key_o, press_o, release_o, long_o}, 32'd0);
        key_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("areset_outs_held", {28'd0, key_o, press_o, release_o, long_o}, 32'd0);
        rst_n = 1'b1;
        set_key(0, 63, 1'b0);
        run_vec(10);
        chk("areset_repress_cnt", n_press, 1);
        chk("areset_repress_cyc", first_press, 6);
        chk("areset_rel_cnt", n_rel, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-side counterpart to the LED-driving logic on the evaluation boards: conditions the raw, bouncing push-button pad into a clean, polarity-corrected level plus single-cycle event pulses. It sits between the top-level button pin and any user logic that consumes key presses, such as counter enables, mode selects or LED pattern stepping. It synchronises the pad, debounces it with a stability counter, and detects press, release and long-press events.

## Interface
- `DEBOUNCE_CYCLES`, default 270000: cycles of stable input needed to accept a level change (10 ms at 27 MHz); must be ≥1.
- `LONG_CYCLES`, default 27000000: cycles after `press_o` at which `long_o` fires (1 s at 27 MHz); must be > `DEBOUNCE_CYCLES`.
- `INV_BTN`, default 1: 1 when the pad reads 0 while pressed (active-low button); 0 otherwise.
- `clk` input 1: the single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_i` input 1: raw button pad, asynchronous to `clk`.
- `key_o` output 1: debounced level, 1 = pressed.
- `press_o` output 1: one-cycle pulse when a press is accepted.
- `release_o` output 1: one-cycle pulse when a release is accepted.
- `long_o` output 1: one-cycle pulse, at most once per press, when the hold reaches `LONG_CYCLES`.

## Operation
- **Synchroniser.** Two flops on `key_i`, both reset to `INV_BTN` (the released level). The pressed flag is `p = sync_q ^ INV_BTN`.
- **FSM states:** RELEASED, DB_PRESS, PRESSED, DB_RELEASE. Reset state is RELEASED.
- **RELEASED:** if `p=1`, go to DB_PRESS with the stability counter cleared.
- **DB_PRESS:** if `p=0`, return to RELEASED; this is a bounce and produces no pulse. If `p=1`, increment the counter.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with `p=1`, go to PRESSED.
  - On that transition: `key_o←1`, `press_o` pulses, hold counter cleared, long flag cleared.
- **PRESSED:** the hold counter increments each cycle and saturates.
  - When it reaches `LONG_CYCLES-1` and the long flag is clear, `long_o` pulses and the long flag is set.
  - If `p=0`, go to DB_RELEASE with the stability counter cleared.
- **DB_RELEASE:** `key_o` stays 1 and the hold counter keeps running, including the long-press check.
  - If `p=1`, return to PRESSED. The hold counter and long flag are kept.
  - When the counter reaches `DEBOUNCE_CYCLES-1` with `p=0`, go to RELEASED: `key_o←0`, `release_o` pulses, hold counter cleared.
- **Mutual exclusion:** `press_o`, `release_o` and `long_o` are never high in the same cycle. A long-press pulse coinciding with release acceptance is dropped; release wins.
- **Arithmetic:** both counters are `$clog2(LONG_CYCLES+1)` bits wide, unsigned. No wrap is allowed; the hold counter saturates at `LONG_CYCLES-1`.

## Timing
- **Reset values:** `key_o=0`, `press_o=0`, `release_o=0`, `long_o=0`; synchroniser flops = `INV_BTN`; counters = 0.
- **Reset is asynchronous** and takes effect immediately, including mid-debounce or mid-hold. No pulse is emitted on reset entry or exit. A button held through reset deassertion produces `press_o` after the normal debounce latency.
- **Press latency:** for a clean edge sampled at clock edge 0, `press_o` is high in cycle 2+`DEBOUNCE_CYCLES`. `key_o` rises in the same cycle as `press_o`.
- **Release latency:** identical in form, measured from the release edge; `release_o` is high in cycle 2+`DEBOUNCE_CYCLES`.
- **Long latency:** `long_o` is high exactly `LONG_CYCLES` cycles after `press_o`, provided no release is accepted first.
- **Bounce rejection:** any input glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- **All outputs are registered;** there is no combinational path from `key_i` to any output.

## Structure
- **Package `key_pkg`:** `key_state_t` enum (RELEASED, DB_PRESS, PRESSED, DB_RELEASE) and a `cnt_width(long_cycles)` function.
- **Sub-module `sync_2ff`:** one-bit two-flop synchroniser with parameter `RST_VAL`. It is reused for other pad inputs.
- **FSM, counters and output registers** live in `key_debounce`.
- Expected size is about 150 lines of RTL.

All bench scenarios use `DEBOUNCE_CYCLES=4`, `LONG_CYCLES=20`, `INV_BTN=1`.

## Test plan
- **Reset:** hold `rst_n=0` with `key_i=0` (pressed), then release reset → all outputs 0; `press_o` is high in cycle 6 after reset deassertion, assuming the first sampling edge is cycle 0.
- **Clean press/release:** drive `key_i` 1→0 at edge 0 → `press_o` high in cycle 6 only, `key_o=1`. Drive `key_i` back to 1 at edge 10 → `release_o` high in cycle 16 only, `key_o=0`.
- **Bounce:** toggle `key_i` 0/1 every 2 cycles for 12 cycles, then hold 0 → exactly one `press_o`, 6 cycles after the final edge. There is no `release_o`.
- **Long press:** hold pressed for 40 cycles → `press_o` in cycle 6, `long_o` once in cycle 26. On release, `release_o` pulses and there is no second `long_o`.
- **Release bounce during hold:** release for 2 cycles at hold cycle 10, then press again → `key_o` stays 1 and there is no `release_o`. `long_o` still fires 20 cycles after `press_o`.
- **Async reset mid-hold:** assert `rst_n=0` while in PRESSED with the hold counter at 10 → outputs go 0 immediately. There is no `release_o`; after reset, re-press produces a fresh `press_o`.
